// File: rtl/param_reg_file.sv
// Multi-port register file with byte-enabled writes, write-through read bypass,
// per-register pending flags and a sequential clear engine.
module param_reg_file #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W/8-1:0]      wr_be,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     mark_en,
  input  logic [ADDR_W-1:0]        mark_addr,
  input  logic                     clr_req,
  output logic                     clr_busy
);

  localparam int              DEPTH = 1 << ADDR_W;
  localparam int              NB    = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                clr_busy_q, clr_busy_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DEPTH-1:0]    pend_q, pend_d;

  logic idle;
  logic wr_ok;
  logic mark_ok;

  assign idle    = (state_q == IDLE);
  assign wr_ok   = we && !((ZERO_R0 != 0) && (wr_addr == '0));
  assign mark_ok = mark_en && !((ZERO_R0 != 0) && (mark_addr == '0));

  always_comb begin
    // NOTE: every _d starts from its _q so no path leaves a value unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    pend_d  = pend_q;
    if (state_q == CLEAR) begin
      mem_d[cnt_q]  = '0;
      pend_d[cnt_q] = 1'b0;
      cnt_d         = cnt_q + ADDR_W'(1);
      if (cnt_q == LAST) state_d = IDLE;
    end else if (clr_req) begin
      state_d = CLEAR;
      cnt_d   = '0;
    end else begin
      if (wr_ok) begin
        for (int b = 0; b < NB; b++) begin
          if (wr_be[b]) mem_d[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
        end
        pend_d[wr_addr] = 1'b0;
      end
      // A same-edge mark is applied after the write's clear, so mark wins.
      if (mark_ok) pend_d[mark_addr] = 1'b1;
    end
    clr_busy_d = (state_d == CLEAR);
  end

  // NOTE: the storage array is reset too, because an async clear of every register is required.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clr_busy_q <= 1'b0;
      pend_q     <= '0;
      mem_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_busy_q <= clr_busy_d;
      pend_q     <= pend_d;
      mem_q      <= mem_d;
    end
  end

  assign clr_busy = clr_busy_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              zero_hit;

    assign a        = rd_addr[i*ADDR_W +: ADDR_W];
    assign zero_hit = (ZERO_R0 != 0) && (a == '0);

    // Write-through bypass merges enabled bytes of the in-flight write.
    always_comb begin
      d = mem_q[a];
      if (idle && wr_ok && (a == wr_addr)) begin
        for (int b = 0; b < NB; b++) begin
          if (wr_be[b]) d[b*8 +: 8] = wr_data[b*8 +: 8];
        end
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = zero_hit ? '0 : d;
    assign rd_pend[i]                  = zero_hit ? 1'b0 : pend_q[a];
  end

endmodule

// File: tb/tb_param_reg_file.sv
// Scoreboard bench for param_reg_file: a reference model predicts every read
// port and clr_busy each cycle; predictions are queued and compared on sampling.
module tb_param_reg_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pend;
  logic        we;
  logic [4:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        mark_en;
  logic [4:0]  mark_addr;
  logic        clr_req;
  logic        clr_busy;

  always #5 clk = ~clk;

  param_reg_file #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_R0(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
    .we(we), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .mark_en(mark_en), .mark_addr(mark_addr), .clr_req(clr_req), .clr_busy(clr_busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int busy_seen;

  logic [31:0] m_mem [32];
  logic        m_pend [32];
  logic        m_busy;
  logic [4:0]  m_cnt;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        pend;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) begin
      m_mem[k]  = '0;
      m_pend[k] = 1'b0;
    end
    m_busy = 1'b0;
    m_cnt  = '0;
  endtask

  function automatic exp_t predict(input string tag, input logic [4:0] a);
    exp_t e;
    e.tag  = tag;
    e.data = m_mem[a];
    e.pend = m_pend[a];
    if (!m_busy && we && a == wr_addr && a != 0) begin
      for (int b = 0; b < 4; b++) if (wr_be[b]) e.data[b*8 +: 8] = wr_data[b*8 +: 8];
    end
    if (a == 0) begin
      e.data = '0;
      e.pend = 1'b0;
    end
    return e;
  endfunction

  // Applies one rising edge to the model using the currently driven inputs.
  task automatic model_step();
    if (m_busy) begin
      m_mem[m_cnt]  = '0;
      m_pend[m_cnt] = 1'b0;
      if (m_cnt == 5'd31) m_busy = 1'b0;
      m_cnt = m_cnt + 5'd1;
    end else if (clr_req) begin
      m_busy = 1'b1;
      m_cnt  = '0;
    end else begin
      if (we && wr_addr != 0) begin
        for (int b = 0; b < 4; b++) if (wr_be[b]) m_mem[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
        m_pend[wr_addr] = 1'b0;
      end
      if (mark_en && mark_addr != 0) m_pend[mark_addr] = 1'b1;
    end
  endtask

  task automatic sample_reads(input logic [4:0] ra0, input logic [4:0] ra1);
    logic exp_busy;
    rd_addr = {ra1, ra0};
    sb.push_back(predict("rd0", ra0));
    sb.push_back(predict("rd1", ra1));
    exp_busy = m_busy;
    #1;
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      e = sb.pop_front();
      check({e.tag, "_data"}, rd_data[i*32 +: 32], e.data);
      check({e.tag, "_pend"}, {31'd0, rd_pend[i]}, {31'd0, e.pend});
    end
    check("clr_busy", {31'd0, clr_busy}, {31'd0, exp_busy});
    busy_seen += int'(clr_busy);
  endtask

  task automatic cycle(input logic w, input logic [4:0] wa, input logic [3:0] be,
                       input logic [31:0] wd, input logic mk, input logic [4:0] ma,
                       input logic clr, input logic [4:0] ra0, input logic [4:0] ra1);
    @(negedge clk);
    we = w; wr_addr = wa; wr_be = be; wr_data = wd;
    mark_en = mk; mark_addr = ma; clr_req = clr;
    sample_reads(ra0, ra1);
    @(posedge clk);
    model_step();
  endtask

  task automatic idle_read(input logic [4:0] ra0, input logic [4:0] ra1);
    cycle(1'b0, 5'd0, 4'h0, 32'd0, 1'b0, 5'd0, 1'b0, ra0, ra1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    we = 0; wr_addr = 0; wr_be = 0; wr_data = 0;
    mark_en = 0; mark_addr = 0; clr_req = 0; rd_addr = 0;
    busy_seen = 0;
    model_reset();

    #12;
    sample_reads(5'd5, 5'd31);
    @(negedge clk);
    rst = 1'b1;

    // Full write then read back.
    cycle(1'b1, 5'd5, 4'hF, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
    idle_read(5'd5, 5'd1);
    // Partial write with same-cycle bypass on port 1, stored value afterward.
    cycle(1'b1, 5'd5, 4'b0011, 32'h00001234, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5);
    idle_read(5'd5, 5'd5);
    // Register 0 is hard-wired.
    cycle(1'b1, 5'd0, 4'hF, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    idle_read(5'd0, 5'd0);
    // Pending flag behaviour on r7.
    cycle(1'b0, 5'd0, 4'h0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd0);
    idle_read(5'd7, 5'd7);
    cycle(1'b1, 5'd7, 4'hF, 32'h11223344, 1'b1, 5'd7, 1'b0, 5'd7, 5'd7);
    idle_read(5'd7, 5'd7);
    cycle(1'b1, 5'd7, 4'h1, 32'h000000AA, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0);
    idle_read(5'd7, 5'd7);

    // Random traffic without clears.
    for (int k = 0; k < 60; k++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom), 4'($urandom), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom), 1'b0, 5'($urandom), 5'($urandom));
    end

    // Fill r1..r31, then clear with a same-edge write that must be dropped.
    for (int a = 1; a < 32; a++) begin
      cycle(1'b1, 5'(a), 4'hF, $urandom | 32'h1, 1'($urandom_range(0, 1)), 5'($urandom),
            1'b0, 5'(a), 5'($urandom));
    end
    cycle(1'b1, 5'd3, 4'hF, 32'hCAFEF00D, 1'b0, 5'd0, 1'b1, 5'd3, 5'd4);
    busy_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (k < 31)
        cycle(1'b1, 5'($urandom), 4'hF, $urandom, 1'b1, 5'($urandom), 1'($urandom_range(0, 1)),
              5'($urandom), 5'(k));
      else
        idle_read(5'($urandom), 5'(k - 31));
    end
    check("busy_cycles", 32'(busy_seen), 32'd32);
    for (int a = 0; a < 32; a += 2) idle_read(5'(a), 5'(a + 1));
    for (int a = 1; a < 32; a++) check("cleared_model", m_mem[a] | 32'(m_pend[a]), 32'd0);

    // Reset in the middle of a clear sequence.
    for (int a = 1; a < 32; a++) cycle(1'b1, 5'(a), 4'hF, 32'h5A5A0000 | 32'(a), 1'b1, 5'(a),
                                       1'b0, 5'(a), 5'd0);
    cycle(1'b0, 5'd0, 4'h0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd20, 5'd30);
    for (int k = 0; k < 10; k++) idle_read(5'd20, 5'd30);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    sample_reads(5'd20, 5'd30);
    @(posedge clk);
    #1;
    check("busy_in_reset", {31'd0, clr_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b1, 5'd9, 4'hF, 32'h0BADF00D, 1'b0, 5'd0, 1'b0, 5'd9, 5'd20);
    idle_read(5'd9, 5'd31);

    if (sb.size() != 0) check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
